// File: rtl/fpu_pkg.sv
// Shared FP types for the FCLASS unit: class-mask bit positions,
// decoded operand predicates and the predicate-to-mask mapping.
package fpu_pkg;

    typedef logic [9:0] fclass_mask_t;

    localparam int FCLS_NINF  = 0;
    localparam int FCLS_NNORM = 1;
    localparam int FCLS_NSUB  = 2;
    localparam int FCLS_NZERO = 3;
    localparam int FCLS_PZERO = 4;
    localparam int FCLS_PSUB  = 5;
    localparam int FCLS_PNORM = 6;
    localparam int FCLS_PINF  = 7;
    localparam int FCLS_SNAN  = 8;
    localparam int FCLS_QNAN  = 9;

    typedef struct packed {
        logic s;
        logic e_ones;
        logic e_zero;
        logic m_zero;
        logic m_msb;
        logic box_ok;
    } fclass_pred_t;

    // Checks are ordered; the first match wins, so exactly one bit is set.
    function automatic fclass_mask_t fclass_mask(input fclass_pred_t p);
        fclass_mask_t m;
        m = '0;
        if (!p.box_ok || (p.e_ones && p.m_msb))
            m[FCLS_QNAN] = 1'b1;
        else if (p.e_ones && !p.m_zero)
            m[FCLS_SNAN] = 1'b1;
        else if (p.e_ones)
            m[p.s ? FCLS_NINF : FCLS_PINF] = 1'b1;
        else if (p.e_zero && p.m_zero)
            m[p.s ? FCLS_NZERO : FCLS_PZERO] = 1'b1;
        else if (p.e_zero)
            m[p.s ? FCLS_NSUB : FCLS_PSUB] = 1'b1;
        else
            m[p.s ? FCLS_NNORM : FCLS_PNORM] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/fclass_decode.sv
// Combinational field decode of one FP operand into class predicates,
// including the NaN-box check of the register bits above the format.
module fclass_decode
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FLEN  = 32
) (
    input  logic [FLEN-1:0] data,
    output fclass_pred_t    pred
);

    localparam int F = 1 + EXP_W + MAN_W;

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             box_ok;

    assign e = data[F-2:MAN_W];
    assign m = data[MAN_W-1:0];

    generate
        if (FLEN > F) begin : g_box
            assign box_ok = &data[FLEN-1:F];
        end else begin : g_nobox
            assign box_ok = 1'b1;
        end
    endgenerate

    assign pred.s      = data[F-1];
    assign pred.e_ones = &e;
    assign pred.e_zero = ~|e;
    assign pred.m_zero = ~|m;
    assign pred.m_msb  = m[MAN_W-1];
    assign pred.box_ok = box_ok;

endmodule

// File: rtl/fclass_pipe.sv
// Elastic FCLASS pipeline: stage 0 holds decoded predicates, middle
// stages delay, the last stage holds the class mask and skid-free stalls.
module fclass_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int FLEN   = 32,
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FLEN-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_mask,
    output logic [TAG_W-1:0] out_tag
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ok;
    logic [TAG_W-1:0]  tq [STAGES];
    fclass_mask_t      mask_q;
    fclass_pred_t      dec;
    fclass_pred_t      last_pred;
    logic              last_vld;

    fclass_decode #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .FLEN  (FLEN)
    ) u_decode (
        .data (in_data),
        .pred (dec)
    );

    // ok[i]: stage i may load this cycle (empty somewhere at or below it).
    always_comb begin
        logic r;
        r = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            r     = r | ~v[i];
            ok[i] = r;
        end
    end

    assign in_ready = ok[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < STAGES; i++)
                tq[i] <= '0;
        end else begin
            if (ok[0] && in_valid)
                tq[0] <= in_tag;
            for (int i = 1; i < STAGES; i++)
                if (ok[i] && v[i-1])
                    tq[i] <= tq[i-1];
            if (flush) begin
                v <= '0;
            end else begin
                if (ok[0])
                    v[0] <= in_valid;
                for (int i = 1; i < STAGES; i++)
                    if (ok[i])
                        v[i] <= v[i-1];
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            assign last_pred = dec;
            assign last_vld  = in_valid;
        end else begin : g_multi
            fclass_pred_t pq [STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < STAGES - 1; i++)
                        pq[i] <= '0;
                end else begin
                    if (ok[0] && in_valid)
                        pq[0] <= dec;
                    for (int i = 1; i < STAGES - 1; i++)
                        if (ok[i] && v[i-1])
                            pq[i] <= pq[i-1];
                end
            end

            assign last_pred = pq[STAGES-2];
            assign last_vld  = v[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mask_q <= '0;
        else if (ok[STAGES-1] && last_vld)
            mask_q <= fclass_mask(last_pred);
    end

    assign out_valid = v[STAGES-1];
    assign out_tag   = tq[STAGES-1];
    assign out_mask  = XLEN'(mask_q);

endmodule

// File: tb/tb_fclass_pipe.sv
// Scoreboard bench for fclass_pipe: single, boxed-single and double
// configurations, backpressure, flush and asynchronous reset.
module tb_fclass_pipe;

    typedef struct {
        logic [9:0] mask;
        logic [4:0] tag;
        int         acc;
        bit         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_mask;
    logic [4:0]  out_tag;

    logic        x_flush = 1'b0;
    logic        x_ready = 1'b1;
    logic [4:0]  x_tag = '0;
    logic        b_valid = 1'b0;
    logic        b_in_ready;
    logic [63:0] b_data = '0;
    logic        b_out_valid;
    logic [31:0] b_mask;
    logic [4:0]  b_tag;
    logic        d_valid = 1'b0;
    logic        d_in_ready;
    logic [63:0] d_data = '0;
    logic        d_out_valid;
    logic [31:0] d_mask;
    logic [4:0]  d_tag;

    exp_t       q[$];
    logic [9:0] qb[$];
    logic [9:0] qd[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_n = 0;
    logic [4:0] tagc = 5'd1;

    fclass_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_tag   (out_tag)
    );

    fclass_pipe #(.EXP_W(8), .MAN_W(23), .FLEN(64)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (x_flush),
        .in_valid  (b_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_data),
        .in_tag    (x_tag),
        .out_valid (b_out_valid),
        .out_ready (x_ready),
        .out_mask  (b_mask),
        .out_tag   (b_tag)
    );

    fclass_pipe #(.EXP_W(11), .MAN_W(52), .FLEN(64)) dut_d (
        .clk       (clk),
        .rst       (rst),
        .flush     (x_flush),
        .in_valid  (d_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_data),
        .in_tag    (x_tag),
        .out_valid (d_out_valid),
        .out_ready (x_ready),
        .out_mask  (d_mask),
        .out_tag   (d_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Main scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual mask %h tag %h required none",
                         out_mask, out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_mask", 64'(out_mask), 64'(e.mask));
                chk("out_tag", 64'(out_tag), 64'(e.tag));
                if (e.lat)
                    chk("latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b actual %h required none", b_mask);
            end else begin
                chk("b_mask", 64'(b_mask), 64'(qb.pop_front()));
                chk("b_tag", 64'(b_tag), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d_out_valid) begin
            if (qd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_d actual %h required none", d_mask);
            end else begin
                chk("d_mask", 64'(d_mask), 64'(qd.pop_front()));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [9:0] m,
                        input bit expect_out, input bit lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = tagc;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual in_ready 0 required 1");
        end else begin
            acc_n++;
            if (expect_out)
                q.push_back('{m, tagc, cyc, lat});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tagc = tagc + 5'd1;
    endtask

    task automatic send_x(input bit sel, input logic [63:0] d,
                          input logic [9:0] m);
        if (!sel) begin
            b_valid = 1'b1;
            b_data  = d;
        end else begin
            d_valid = 1'b1;
            d_data  = d;
        end
        @(negedge clk);
        if (!sel) qb.push_back(m);
        else      qd.push_back(m);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] vec [10];
        logic [9:0]  msk [10];
        int n;

        vec = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                32'h00000000, 32'h80000000, 32'h00000001, 32'h80000001,
                32'h3F800000, 32'hBF800000};
        msk = '{10'h080, 10'h001, 10'h200, 10'h100, 10'h010,
                10'h008, 10'h020, 10'h004, 10'h040, 10'h002};

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_mask", 64'(out_mask), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed classes, streaming one per cycle.
        for (int i = 0; i < 10; i++)
            send(vec[i], msk[i], 1'b1, 1'b1);

        // Boxed single and double formats.
        send_x(1'b0, 64'hFFFFFFFF3F800000, 10'h040);
        send_x(1'b0, 64'h000000003F800000, 10'h200);
        send_x(1'b0, 64'hFFFFFFFF7F800000, 10'h080);
        send_x(1'b0, 64'hFFFFFFFEFF800000, 10'h200);
        send_x(1'b1, 64'h7FF0000000000000, 10'h080);
        send_x(1'b1, 64'h0008000000000000, 10'h020);
        send_x(1'b1, 64'h7FF4000000000000, 10'h100);
        send_x(1'b1, 64'hFFF8000000000000, 10'h200);
        send_x(1'b1, 64'h8000000000000000, 10'h008);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: hold out_ready low around the first result.
        out_ready = 1'b0;
        acc_n = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(vec[i], msk[i], 1'b1, 1'b0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepts", 64'(acc_n), 64'd2);
                repeat (5) @(negedge clk);
                chk("bp_still_full", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("bp_drained", 64'(q.size()), 64'd0);
        #1;

        // Flush two stalled operands, then check the next one's latency.
        out_ready = 1'b0;
        send(32'h3F800000, 10'h040, 1'b0, 1'b0);
        send(32'hBF800000, 10'h002, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b1;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        send(32'h00000001, 10'h020, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        send(32'h7F800000, 10'h080, 1'b0, 1'b0);
        send(32'hFF800000, 10'h001, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_out_mask", 64'(out_mask), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h80000000, 10'h008, 1'b1, 1'b1);

        n = 0;
        while ((q.size() != 0 || qb.size() != 0 || qd.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("final_drain", 64'(q.size() + qb.size() + qd.size()), 64'd0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

endmodule
